// File: rtl/bus_arbiter_4x1_pkg.sv
// Shared definitions for the result-bus controllers: state encoding, requester
// count, default data width and the round-robin search helper.
package bus_arbiter_4x1_pkg;

    localparam int unsigned NumReq       = 4;
    localparam int unsigned DefaultWidth = 32;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Search last+1, last+2, last+3, last (mod 4); the first asserted request wins.
    function automatic pick_t rr_pick(input logic [1:0] last, input logic [NumReq-1:0] req);
        pick_t      p;
        logic [1:0] cand;
        p = '0;
        for (int unsigned off = 1; off <= NumReq; off++) begin
            cand = last + 2'(off);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    function automatic logic [NumReq-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_4x1_if.sv
// Requester/bus bundle between the result sources, the arbiter and the
// register-file write port.
interface bus_arbiter_4x1_if
    import bus_arbiter_4x1_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic [NumReq-1:0] req;
    logic [WIDTH-1:0]  d0;
    logic [WIDTH-1:0]  d1;
    logic [WIDTH-1:0]  d2;
    logic [WIDTH-1:0]  d3;
    logic [NumReq-1:0] gnt;
    logic [1:0]        sel;
    logic [WIDTH-1:0]  bus_data;
    logic              bus_valid;

    // Arbiter side: consumes requests and words, drives grant and bus.
    modport master (
        input  req, d0, d1, d2, d3,
        output gnt, sel, bus_data, bus_valid
    );

    // Requester/consumer side.
    modport slave (
        output req, d0, d1, d2, d3,
        input  gnt, sel, bus_data, bus_valid
    );

endinterface

// File: rtl/bus_arbiter_4x1_mux.sv
// Plain 4:1 word mux; s selects I0..I3.
module mux_4x1_32bit #(
    parameter int unsigned W = 32
) (
    output logic [W-1:0] Y,
    input  logic [1:0]   s,
    input  logic [W-1:0] I3,
    input  logic [W-1:0] I2,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] I0
);

    // Combinational select.
    always_comb begin
        Y = I0;
        case (s)
            2'd0:    Y = I0;
            2'd1:    Y = I1;
            2'd2:    Y = I2;
            2'd3:    Y = I3;
            default: Y = I0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter_4x1.sv
// Round-robin arbiter for one shared result bus: grants one requester at a time
// for at most MAX_BURST beats and registers the muxed word with a valid flag.
module bus_arbiter_4x1
    import bus_arbiter_4x1_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk,
    input logic               reset,
    bus_arbiter_4x1_if.master bus
);

    localparam int unsigned     CntW     = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]  bus_data_q, bus_data_d;
    logic              bus_valid_q, bus_valid_d;
    logic [WIDTH-1:0]  mux_y;
    logic              release_owner;
    pick_t             pick;
    pick_t             repick;

    mux_4x1_32bit #(
        .W (WIDTH)
    ) u_mux (
        .Y  (mux_y),
        .s  (sel_q),
        .I3 (bus.d3),
        .I2 (bus.d2),
        .I1 (bus.d1),
        .I0 (bus.d0)
    );

    // Arbitration, beat transfer and release/handoff decisions.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        last_d        = last_q;
        beat_cnt_d    = beat_cnt_q;
        bus_data_d    = bus_data_q;
        bus_valid_d   = 1'b0;
        release_owner = 1'b0;
        pick          = rr_pick(last_q, bus.req);
        repick        = rr_pick(sel_q, bus.req);

        unique case (state_q)
            StIdle: begin
                // Grant only; the first beat moves on the following edge.
                if (pick.found) begin
                    state_d    = StBusy;
                    sel_d      = pick.idx;
                    gnt_d      = idx_to_onehot(pick.idx);
                    beat_cnt_d = '0;
                end
            end
            StBusy: begin
                if (bus.req[sel_q]) begin
                    bus_data_d    = mux_y;
                    bus_valid_d   = 1'b1;
                    beat_cnt_d    = beat_cnt_q + CntW'(1);
                    release_owner = (beat_cnt_q == LastBeat);
                end else begin
                    release_owner = 1'b1;
                end

                // Re-arbitrate from the departing owner so a sole requester wraps
                // back to itself without a bubble.
                if (release_owner) begin
                    last_d     = sel_q;
                    beat_cnt_d = '0;
                    if (repick.found) begin
                        sel_d = repick.idx;
                        gnt_d = idx_to_onehot(repick.idx);
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous reset; last=3 gives requester 0 first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            sel_q       <= '0;
            last_q      <= 2'd3;
            beat_cnt_q  <= '0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            beat_cnt_q  <= beat_cnt_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.bus_data  = bus_data_q;
    assign bus.bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// Directed bench for bus_arbiter_4x1: expected beats are queued by the stimulus
// and popped by a monitor on every valid bus beat.
module tb_bus_arbiter_4x1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_arbiter_4x1_if #(.WIDTH(32)) bus_if ();

    bus_arbiter_4x1 #(
        .WIDTH     (32),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] dv[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] a, b, c, d);
        bus_if.d0 = a;
        bus_if.d1 = b;
        bus_if.d2 = c;
        bus_if.d3 = d;
    endtask

    // Monitor: every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus_if.bus_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %h expected no beat", bus_if.bus_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("beat_data", bus_if.bus_data, mon_exp);
            end
        end
    end

    initial begin
        dv[0] = 32'h00000000;
        dv[1] = 32'h00001111;
        dv[2] = 32'h11110000;
        dv[3] = 32'h11111111;

        // 1: reset held with all requests
        reset      = 1'b1;
        bus_if.req = 4'hF;
        set_data(dv[0], dv[1], dv[2], dv[3]);
        repeat (2) step();
        chk("reset_gnt", 32'(bus_if.gnt), 32'h0);
        chk("reset_sel", 32'(bus_if.sel), 32'h0);
        chk("reset_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("reset_data", bus_if.bus_data, 32'h0);
        reset = 1'b0;
        step();
        chk("first_gnt", 32'(bus_if.gnt), 32'h1);
        bus_if.req = 4'h0;
        step();
        chk("first_release_gnt", 32'(bus_if.gnt), 32'h0);
        chk("first_release_valid", 32'(bus_if.bus_valid), 32'h0);

        // 2: sole requester 0 hits the burst cap and is regranted without a gap
        set_data(32'h00001111, dv[1], dv[2], dv[3]);
        bus_if.req = 4'b0001;
        step();
        chk("cap_gnt", 32'(bus_if.gnt), 32'h1);
        chk("cap_grant_valid", 32'(bus_if.bus_valid), 32'h0);
        repeat (6) exp_q.push_back(32'h00001111);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("cap_valid", 32'(bus_if.bus_valid), 32'h1);
            chk("cap_gnt_held", 32'(bus_if.gnt), 32'h1);
        end
        bus_if.req = 4'h0;
        step();
        chk("cap_end_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("cap_end_gnt", 32'(bus_if.gnt), 32'h0);

        // 3: round robin over all four from a fresh pointer
        reset = 1'b1;
        #1;
        reset = 1'b0;
        set_data(dv[0], dv[1], dv[2], dv[3]);
        bus_if.req = 4'hF;
        step();
        chk("rr_gnt0", 32'(bus_if.gnt), 32'h1);
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(dv[g % 4]);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rr_valid", 32'(bus_if.bus_valid), 32'h1);
            if (i % 4 == 3) chk("rr_gnt", 32'(bus_if.gnt), 32'(4'b0001 << (((i + 1) / 4) % 4)));
        end
        bus_if.req = 4'h0;
        step();
        chk("rr_end_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("rr_end_gnt", 32'(bus_if.gnt), 32'h0);

        // 4: owner 1 drops after 2 beats while 3 waits
        bus_if.req = 4'b0010;
        step();
        chk("drop_gnt1", 32'(bus_if.gnt), 32'h2);
        bus_if.req = 4'b1010;
        exp_q.push_back(dv[1]);
        exp_q.push_back(dv[1]);
        repeat (2) begin
            step();
            chk("drop_beat_valid", 32'(bus_if.bus_valid), 32'h1);
        end
        bus_if.req = 4'b1000;
        step();
        chk("drop_gap_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("drop_hold_data", bus_if.bus_data, dv[1]);
        chk("drop_gnt3", 32'(bus_if.gnt), 32'h8);
        exp_q.push_back(dv[3]);
        step();
        chk("drop_beat3_valid", 32'(bus_if.bus_valid), 32'h1);
        bus_if.req = 4'h0;
        step();
        chk("drop_end_gnt", 32'(bus_if.gnt), 32'h0);

        // 5: asynchronous reset in the middle of a burst
        bus_if.req = 4'b0010;
        step();
        chk("mid_gnt1", 32'(bus_if.gnt), 32'h2);
        bus_if.req = 4'b0111;
        set_data(32'h00001111, dv[1], dv[2], dv[3]);
        exp_q.push_back(dv[1]);
        step();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_gnt", 32'(bus_if.gnt), 32'h0);
        chk("mid_reset_sel", 32'(bus_if.sel), 32'h0);
        chk("mid_reset_valid", 32'(bus_if.bus_valid), 32'h0);
        chk("mid_reset_data", bus_if.bus_data, 32'h0);
        reset = 1'b0;
        step();
        chk("mid_rr_after_reset", 32'(bus_if.gnt), 32'h1);
        exp_q.push_back(32'h00001111);
        step();
        chk("mid_beat_valid", 32'(bus_if.bus_valid), 32'h1);
        bus_if.req = 4'h0;
        step();
        chk("mid_end_valid", 32'(bus_if.bus_valid), 32'h0);

        // 6: idle, bus data must hold while inputs wiggle
        set_data(32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_gnt", 32'(bus_if.gnt), 32'h0);
            chk("idle_valid", 32'(bus_if.bus_valid), 32'h0);
            chk("idle_data", bus_if.bus_data, 32'h00001111);
        end

        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
